// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Data-memory responder for the processor's dmem port. Word RAM occupies the
//   low address space; the top of the 12-bit word space holds memory-mapped
//   I/O: console TX byte FIFO (0xFF0), status/control (0xFF1), free-running
//   cycle counter (0xFF2) and a scratch register (0xFF3).
//   Read data is registered (one-cycle latency, read-before-write), matching
//   the syncram it replaces.
//
//   Build option: define DMEM_CYCLE_COUNTER_EN to include the cycle counter.
//   Without it, 0xFF2 decodes as unmapped and no counter logic is built.

module dmem_mmio_responder #(
    parameter int RAM_AW  = 11,
    parameter int FIFO_AW = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FIFO_FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    localparam logic [11:0] ADDR_TXDATA  = 12'hFF0;
    localparam logic [11:0] ADDR_STATUS  = 12'hFF1;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam logic [11:0] ADDR_CYCLE   = 12'hFF2;
`endif
    localparam logic [11:0] ADDR_SCRATCH = 12'hFF3;

    // STATUS bit that clears the sticky overflow flag when written as 1
    localparam int STATUS_OVF_BIT = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE,
        SEL_SCRATCH
    } sel_e;

    sel_e sel;

    // Storage
    logic [31:0]        ram_q  [2**RAM_AW];
    logic [7:0]         fifo_q [FIFO_DEPTH];

    // Registered state and next-state values
    logic [31:0]        q_dmem_q,   q_dmem_d;
    logic [FIFO_AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [FIFO_AW:0]   count_q,    count_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        scratch_q,  scratch_d;
`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0]        cycle_q,    cycle_d;
`endif

    logic [RAM_AW-1:0]  ram_idx;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               push_accept;
    logic [31:0]        status_word;

    assign ram_idx     = address_dmem[RAM_AW-1:0];
    assign fifo_full   = (count_q == FIFO_FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign push        = wren && (sel == SEL_TXDATA);
    assign pop         = tx_valid && tx_ready;
    // A push into a full FIFO still lands if the head leaves at the same edge
    assign push_accept = push && (!fifo_full || pop);
    assign status_word = {20'd0, 8'(count_q), 1'b0, overflow_q, fifo_empty, fifo_full};

    assign q_dmem   = q_dmem_q;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

    // Address decode: MMIO registers first, then the RAM window, else unmapped
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
        sel = SEL_NONE;
        if (address_dmem == ADDR_TXDATA) begin
            sel = SEL_TXDATA;
        end else if (address_dmem == ADDR_STATUS) begin
            sel = SEL_STATUS;
`ifdef DMEM_CYCLE_COUNTER_EN
        end else if (address_dmem == ADDR_CYCLE) begin
            sel = SEL_CYCLE;
`endif
        end else if (address_dmem == ADDR_SCRATCH) begin
            sel = SEL_SCRATCH;
        end else if ((address_dmem >> RAM_AW) == 12'd0) begin
            sel = SEL_RAM;
        end
    end

    // Next-state: read-data mux, FIFO pointers/count, overflow, scratch, counter
    always_comb begin
        q_dmem_d   = 32'd0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        scratch_d  = scratch_q;
`ifdef DMEM_CYCLE_COUNTER_EN
        cycle_d    = cycle_q + 32'd1;
`endif

        // Read data reflects pre-edge state, independent of wren
        case (sel)
            SEL_RAM:     q_dmem_d = ram_q[ram_idx];
            SEL_STATUS:  q_dmem_d = status_word;
`ifdef DMEM_CYCLE_COUNTER_EN
            SEL_CYCLE:   q_dmem_d = cycle_q;
`endif
            SEL_SCRATCH: q_dmem_d = scratch_q;
            default:     q_dmem_d = 32'd0;
        endcase

        if (push_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (wren && (sel == SEL_STATUS) && data[STATUS_OVF_BIT]) begin
            overflow_d = 1'b0;
        end

        if (wren && (sel == SEL_SCRATCH)) begin
            scratch_d = data;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            q_dmem_q   <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            scratch_q  <= 32'd0;
`ifdef DMEM_CYCLE_COUNTER_EN
            cycle_q    <= 32'd0;
`endif
        end else begin
            q_dmem_q   <= q_dmem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            scratch_q  <= scratch_d;
`ifdef DMEM_CYCLE_COUNTER_EN
            cycle_q    <= cycle_d;
`endif
        end
    end

    // Storage arrays: RAM words and FIFO byte slots
    always_ff @(posedge clock) begin
        // NOTE: memories carry no reset; emptiness is tracked by count_q and tx_data is masked when empty.
        if (wren && (sel == SEL_RAM)) begin
            ram_q[ram_idx] <= data;
        end
        if (!reset && push_accept) begin
            fifo_q[wr_ptr_q] <= data[7:0];
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder
//   Directed stimulus with a scoreboard: each read request pushes its expected
//   q_dmem value, each queued console byte pushes its expected tx_data value.
//   A monitor on the falling edge pops and compares when the DUT presents data.

module tb_dmem_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t    rd_exp_q[$];
    logic [7:0] tx_exp_q[$];

    int   total = 0;
    int   bad   = 0;
    logic rd_req     = 1'b0;
    logic chk_q_next = 1'b0;

    always #5 clock = ~clock;

    dmem_mmio_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        step();
        wren         = 1'b0;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_exp_q.push_back(e);
        address_dmem = a;
        wren         = 1'b0;
        rd_req       = 1'b1;
        step();
        rd_req       = 1'b0;
    endtask

    task automatic wrrd(input string name, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        rd_exp_q.push_back(e);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        rd_req       = 1'b1;
        step();
        wren         = 1'b0;
        rd_req       = 1'b0;
    endtask

    task automatic drain(input int n);
        tx_ready = 1'b1;
        repeat (n) step();
        tx_ready = 1'b0;
    endtask

    // Monitor: read data appears the cycle after the sampling edge; a console
    // byte is delivered at any edge where tx_valid & tx_ready
    initial begin
        forever begin
            @(negedge clock);
            if (chk_q_next) begin
                if (rd_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got 0x%08h with no expected read", q_dmem);
                end else begin
                    rd_exp_t e;
                    e = rd_exp_q.pop_front();
                    check(e.name, q_dmem, e.val);
                end
            end
            chk_q_next = rd_req;
            if (tx_valid && tx_ready) begin
                if (tx_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got 0x%02h with no expected byte", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, tx_exp_q.pop_front()});
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        reset        = 1'b1;
        address_dmem = 12'h000;
        data         = 32'd0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        step();
        step();
        check("reset_q_dmem",   q_dmem, 32'd0);
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset_tx_data",  {24'd0, tx_data}, 32'd0);
        reset = 1'b0;

        rd("status_after_reset",  12'hFF1, 32'h0000_0002);
        rd("scratch_after_reset", 12'hFF3, 32'h0000_0000);

        // RAM read/write, unmapped, TXDATA readback, read-before-write
        wr(12'h005, 32'hDEAD_BEEF);
        rd("ram_005", 12'h005, 32'hDEAD_BEEF);
        wr(12'h900, 32'hFFFF_FFFF);
        rd("unmapped_900", 12'h900, 32'h0000_0000);
        rd("txdata_reads_0", 12'hFF0, 32'h0000_0000);
        wr(12'h006, 32'h0000_0001);
        wrrd("ram_006_rbw", 12'h006, 32'h0000_0002, 32'h0000_0001);
        rd("ram_006_new", 12'h006, 32'h0000_0002);

        // Console basic: two bytes queued, only low byte of the write stored
        wr(12'hFF0, 32'h0000_0141);
        wr(12'hFF0, 32'h0000_0042);
        check("tx_valid_queued", {31'd0, tx_valid}, 32'd1);
        check("tx_data_head",    {24'd0, tx_data},  32'h41);
        rd("status_two_queued", 12'hFF1, 32'h0000_0020);
        tx_exp_q.push_back(8'h41);
        tx_exp_q.push_back(8'h42);
        drain(2);
        rd("status_drained", 12'hFF1, 32'h0000_0002);

        // Overflow: ninth byte dropped, sticky flag, write-1 clear
        for (int i = 1; i <= 9; i++) begin
            wr(12'hFF0, 32'(i));
            if (i <= 8) tx_exp_q.push_back(8'(i));
        end
        rd("status_overflow", 12'hFF1, 32'h0000_0085);
        wr(12'hFF1, 32'h0000_0003);
        rd("status_ovf_kept", 12'hFF1, 32'h0000_0085);
        wr(12'hFF1, 32'h0000_0004);
        rd("status_ovf_clear", 12'hFF1, 32'h0000_0081);
        drain(8);
        check("tx_valid_empty", {31'd0, tx_valid}, 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            wr(12'hFF0, 32'h11 + 32'(i));
            tx_exp_q.push_back(8'h11 + 8'(i));
        end
        tx_exp_q.push_back(8'hAA);
        tx_ready = 1'b1;
        wr(12'hFF0, 32'h0000_00AA);
        tx_ready = 1'b0;
        rd("status_full_pushpop", 12'hFF1, 32'h0000_0081);
        drain(8);
        rd("status_after_pushpop", 12'hFF1, 32'h0000_0002);

        // Reset mid-operation: 3 bytes queued, overflow set, scratch written
        for (int i = 0; i < 9; i++) begin
            wr(12'hFF0, 32'h51 + 32'(i));
            if (i < 5) tx_exp_q.push_back(8'h51 + 8'(i));
        end
        drain(5);
        wr(12'hFF3, 32'h0000_1234);
        rd("status_pre_reset",  12'hFF1, 32'h0000_0034);
        rd("scratch_pre_reset", 12'hFF3, 32'h0000_1234);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midreset_tx_data",  {24'd0, tx_data},  32'd0);
        check("midreset_q_dmem",   q_dmem, 32'd0);

        // Cycle counter: the read sampled at the 10th edge after reset sees 9
        repeat (9) step();
`ifdef DMEM_CYCLE_COUNTER_EN
        rd("cycle_edge10", 12'hFF2, 32'd9);
        wr(12'hFF2, 32'h1234_5678);
        rd("cycle_write_ignored", 12'hFF2, 32'd11);
`else
        rd("cycle_edge10", 12'hFF2, 32'd0);
        wr(12'hFF2, 32'h1234_5678);
        rd("cycle_write_ignored", 12'hFF2, 32'd0);
`endif
        rd("status_post_reset",  12'hFF1, 32'h0000_0002);
        rd("scratch_post_reset", 12'hFF3, 32'h0000_0000);
        rd("ram_005_kept",       12'h005, 32'hDEAD_BEEF);

        step();
        step();
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
